// File: rtl/irq_sched.sv
// 27-source interrupt scheduler: sticky pending capture, per-channel masking,
// fixed-priority arbitration (A > B > C, lowest channel first), ack/timeout handshake.
//
// state | meaning
// IDLE  | arbitrate among eligible pending bits; skip register cleared each cycle
// GRANT | grant presented to host, waiting for ack or timeout
module irq_sched #(
  parameter int NCH     = 9,
  parameter int CW      = 4,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [NCH-1:0] req_a,
  input  logic [NCH-1:0] req_b,
  input  logic [NCH-1:0] req_c,
  input  logic [NCH-1:0] mask,
  input  logic           ack,
  output logic           irq_valid,
  output logic [1:0]     irq_bus,
  output logic [CW-1:0]  irq_chan,
  output logic           pend_any,
  output logic           timeout_err
);

  localparam int NSRC = 3 * NCH;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [NSRC-1:0]   pend, pend_nxt;
  logic [NSRC-1:0]   skip, skip_nxt;
  logic [NSRC-1:0]   gnt_oh, gnt_oh_nxt;
  logic [NSRC-1:0]   clr;
  logic [NSRC-1:0]   elig;
  logic [NSRC-1:0]   req_all;
  logic [NSRC-1:0]   mask_all;
  logic [TW-1:0]     cnt, cnt_nxt, cnt_inc;
  logic              timeout_hit;
  logic              win_found;
  logic [1:0]        win_bus;
  logic [CW-1:0]     win_chan;
  logic [NSRC-1:0]   win_oh;
  logic              valid_nxt;
  logic [1:0]        bus_nxt;
  logic [CW-1:0]     chan_nxt;
  logic              err_nxt;

  // Flattened source index: bus*NCH + chan, so ascending index is priority order.
  assign req_all  = {req_c, req_b, req_a};
  assign mask_all = {mask, mask, mask};
  assign elig     = pend & mask_all & ~skip;

  always_comb begin
    win_found = 1'b0;
    win_bus   = '0;
    win_chan  = '0;
    win_oh    = '0;
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!win_found && elig[b*NCH+c]) begin
          win_found        = 1'b1;
          win_bus          = 2'(b);
          win_chan         = CW'(c);
          win_oh[b*NCH+c]  = 1'b1;
        end
      end
    end
  end

  // The counter after this cycle's increment equals the number of GRANT cycles
  // spent so far, so the grant is shown for exactly TIMEOUT cycles.
  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (cnt_inc == TW'(TIMEOUT));

  always_comb begin
    state_nxt  = state;
    clr        = '0;
    skip_nxt   = skip;
    cnt_nxt    = cnt;
    gnt_oh_nxt = gnt_oh;
    valid_nxt  = 1'b0;
    bus_nxt    = irq_bus;
    chan_nxt   = irq_chan;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        skip_nxt = '0;
        cnt_nxt  = '0;
        if (en && win_found) begin
          state_nxt  = GRANT;
          valid_nxt  = 1'b1;
          bus_nxt    = win_bus;
          chan_nxt   = win_chan;
          gnt_oh_nxt = win_oh;
        end
      end
      GRANT: begin
        valid_nxt = 1'b1;
        cnt_nxt   = cnt_inc;
        if (ack) begin
          clr       = gnt_oh;
          cnt_nxt   = '0;
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          err_nxt   = 1'b1;
          skip_nxt  = gnt_oh;
          cnt_nxt   = '0;
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear on ack wins over a same-cycle request on the granted bit.
  assign pend_nxt = (pend | req_all) & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend        <= '0;
      skip        <= '0;
      gnt_oh      <= '0;
      cnt         <= '0;
      irq_valid   <= 1'b0;
      irq_bus     <= '0;
      irq_chan    <= '0;
      pend_any    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend        <= pend_nxt;
      skip        <= skip_nxt;
      gnt_oh      <= gnt_oh_nxt;
      cnt         <= cnt_nxt;
      irq_valid   <= valid_nxt;
      irq_bus     <= bus_nxt;
      irq_chan    <= chan_nxt;
      pend_any    <= |pend_nxt;
      timeout_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_irq_sched.sv
// Bench for irq_sched: directed scenarios with literal expectations, then random
// traffic compared every cycle against a per-source behavioural model.
module tb_irq_sched;
  localparam int NCH = 9;
  localparam int CW = 4;
  localparam int TIMEOUT = 15;
  localparam int TW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [NCH-1:0] req_a, req_b, req_c, mask;
  logic           ack;
  logic           irq_valid;
  logic [1:0]     irq_bus;
  logic [CW-1:0]  irq_chan;
  logic           pend_any;
  logic           timeout_err;

  irq_sched #(.NCH(NCH), .CW(CW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst(rst), .en(en), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .mask(mask), .ack(ack), .irq_valid(irq_valid), .irq_bus(irq_bus),
    .irq_chan(irq_chan), .pend_any(pend_any), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: pending per bus/channel, current grant, grant age, one-shot skip
  logic [NCH-1:0] mp[3];
  bit m_gnt, m_err, m_skip_v;
  int m_b, m_c, m_age, m_skip_b, m_skip_c;

  logic [NCH-1:0] cur_mask;
  logic           cur_en;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) mp[b] = '0;
    m_gnt = 0; m_err = 0; m_skip_v = 0; m_b = 0; m_c = 0; m_age = 0;
    m_skip_b = 0; m_skip_c = 0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] rq[3];
    logic [NCH-1:0] old[3];
    bit acked, tmo, found;
    int fb, fc;
    rq[0] = req_a; rq[1] = req_b; rq[2] = req_c;
    for (int b = 0; b < 3; b++) old[b] = mp[b];
    acked = m_gnt && ack;
    tmo = m_gnt && !ack && (m_age + 1 == TIMEOUT);
    m_err = 0;
    for (int b = 0; b < 3; b++) mp[b] = mp[b] | rq[b];
    if (acked) mp[m_b][m_c] = 1'b0;
    if (!m_gnt) begin
      found = 0; fb = 0; fc = 0;
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < NCH; c++)
          if (!found && old[b][c] && mask[c] &&
              !(m_skip_v && m_skip_b == b && m_skip_c == c)) begin
            found = 1; fb = b; fc = c;
          end
      m_skip_v = 0;
      if (en && found) begin
        m_gnt = 1; m_b = fb; m_c = fc; m_age = 0;
      end
    end else begin
      m_age++;
      if (acked) m_gnt = 0;
      else if (tmo) begin
        m_gnt = 0; m_err = 1; m_skip_v = 1; m_skip_b = m_b; m_skip_c = m_c;
      end
    end
  endtask

  task automatic compare();
    bit any;
    any = |{mp[0], mp[1], mp[2]};
    chk("irq_valid", int'(irq_valid), int'(m_gnt));
    chk("pend_any", int'(pend_any), int'(any));
    chk("timeout_err", int'(timeout_err), int'(m_err));
    if (m_gnt) begin
      chk("irq_bus", int'(irq_bus), m_b);
      chk("irq_chan", int'(irq_chan), m_c);
    end
  endtask

  task automatic cyc(input logic [NCH-1:0] ra, input logic [NCH-1:0] rb,
                     input logic [NCH-1:0] rc, input logic a);
    @(negedge clk);
    req_a = ra; req_b = rb; req_c = rc; mask = cur_mask; en = cur_en; ack = a;
    @(posedge clk);
    #1;
    model_step();
    compare();
  endtask

  task automatic wait_grant(output int b, output int c, output int n);
    n = 0;
    while (!irq_valid && n < 40) begin
      cyc('0, '0, '0, 1'b0);
      n++;
    end
    checks++;
    if (!irq_valid) begin
      failures++;
      $display("FAIL grant_wait: no grant within %0d cycles, expected one", n);
    end
    b = int'(irq_bus);
    c = int'(irq_chan);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int gb, gc, gn, vcnt, errs;
  logic [NCH-1:0] ra, rb, rc;
  int ack_mode;

  initial begin
    rst = 1'b1; en = 1'b1; ack = 1'b0; req_a = '0; req_b = '0; req_c = '0;
    mask = '1; cur_mask = '1; cur_en = 1'b1;
    model_reset();
    #2;
    chk("rst_valid", int'(irq_valid), 0);
    chk("rst_pend_any", int'(pend_any), 0);
    chk("rst_err", int'(timeout_err), 0);
    chk("rst_bus", int'(irq_bus), 0);
    chk("rst_chan", int'(irq_chan), 0);
    @(negedge clk);
    rst = 1'b0;

    // single request, two-edge latency, ack clears
    cyc(9'h008, '0, '0, 1'b0);
    chk("t1_valid_early", int'(irq_valid), 0);
    chk("t1_pend_any", int'(pend_any), 1);
    cyc('0, '0, '0, 1'b0);
    chk("t1_valid", int'(irq_valid), 1);
    chk("t1_bus", int'(irq_bus), 0);
    chk("t1_chan", int'(irq_chan), 3);
    cyc('0, '0, '0, 1'b1);
    chk("t1_valid_after_ack", int'(irq_valid), 0);
    chk("t1_pend_after_ack", int'(pend_any), 0);

    // simultaneous A/8, B/5, C/0
    cyc(9'h100, 9'h020, 9'h001, 1'b0);
    wait_grant(gb, gc, gn);
    chk("t2_g1", gb * 16 + gc, 0 * 16 + 8);
    cyc('0, '0, '0, 1'b1);
    wait_grant(gb, gc, gn);
    chk("t2_g2", gb * 16 + gc, 1 * 16 + 5);
    chk("t2_gap", gn, 1);
    cyc('0, '0, '0, 1'b1);
    wait_grant(gb, gc, gn);
    chk("t2_g3", gb * 16 + gc, 2 * 16 + 0);
    chk("t2_gap2", gn, 1);
    cyc('0, '0, '0, 1'b1);

    // mask blocks A/2 until re-enabled
    cur_mask = ~9'h004;
    cyc(9'h004, 9'h010, '0, 1'b0);
    wait_grant(gb, gc, gn);
    chk("t3_g1", gb * 16 + gc, 1 * 16 + 4);
    cyc('0, '0, '0, 1'b1);
    chk("t3_pend_masked", int'(pend_any), 1);
    cur_mask = '1;
    wait_grant(gb, gc, gn);
    chk("t3_g2", gb * 16 + gc, 0 * 16 + 2);
    cyc('0, '0, '0, 1'b1);
    chk("t3_pend_clear", int'(pend_any), 0);

    // timeout on A/1, B/0 served next, then A/1 again
    cyc(9'h002, '0, '0, 1'b0);
    wait_grant(gb, gc, gn);
    chk("t4_g1", gb * 16 + gc, 0 * 16 + 1);
    vcnt = 1; errs = 0;
    for (int k = 0; k < 40 && errs == 0; k++) begin
      cyc('0, (k == 0) ? 9'h001 : 9'h000, '0, 1'b0);
      if (timeout_err) errs++;
      else if (irq_valid) vcnt++;
    end
    chk("t4_valid_cycles", vcnt, TIMEOUT);
    chk("t4_err_seen", errs, 1);
    chk("t4_valid_drop", int'(irq_valid), 0);
    wait_grant(gb, gc, gn);
    chk("t4_g2", gb * 16 + gc, 1 * 16 + 0);
    cyc('0, '0, '0, 1'b1);
    wait_grant(gb, gc, gn);
    chk("t4_g3", gb * 16 + gc, 0 * 16 + 1);
    cyc('0, '0, '0, 1'b1);

    // ack beats a same-cycle request; a held request re-pends
    cyc(9'h040, '0, '0, 1'b0);
    wait_grant(gb, gc, gn);
    cyc(9'h040, '0, '0, 1'b1);
    chk("t5_clear_wins", int'(pend_any), 0);
    cyc('0, '0, '0, 1'b0);
    chk("t5_no_regrant", int'(irq_valid), 0);
    cyc(9'h040, '0, '0, 1'b0);
    wait_grant(gb, gc, gn);
    cyc(9'h040, '0, '0, 1'b1);
    cyc(9'h040, '0, '0, 1'b0);
    chk("t5_repend", int'(pend_any), 1);
    wait_grant(gb, gc, gn);
    chk("t5_regrant", gb * 16 + gc, 0 * 16 + 6);
    cyc('0, '0, '0, 1'b1);

    // asynchronous reset mid-grant
    cyc('0, '0, 9'h080, 1'b0);
    wait_grant(gb, gc, gn);
    req_a = '0; req_b = '0; req_c = '0; ack = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", int'(irq_valid), 0);
    chk("t6_pend_any", int'(pend_any), 0);
    chk("t6_bus", int'(irq_bus), 0);
    chk("t6_chan", int'(irq_chan), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cyc('0, '0, '0, 1'b0);

    // random traffic
    ack_mode = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) begin
        ack_mode = int'($urandom_range(0, 2));
        cur_mask = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '1;
      end
      cur_en = ($urandom_range(0, 9) != 0);
      ra = ($urandom_range(0, 7) == 0) ? (NCH'(1) << $urandom_range(0, NCH - 1)) : '0;
      rb = ($urandom_range(0, 7) == 0) ? (NCH'(1) << $urandom_range(0, NCH - 1)) : '0;
      rc = ($urandom_range(0, 7) == 0) ? (NCH'(1) << $urandom_range(0, NCH - 1)) : '0;
      case (ack_mode)
        0: cyc(ra, rb, rc, $urandom_range(0, 2) == 0);
        1: cyc(ra, rb, rc, $urandom_range(0, 24) == 0);
        default: cyc(ra, rb, rc, 1'b0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
